// File: rtl/rs_station_age_pkg.sv
// Shared definitions for the age-ordered reservation station.
// Provides default sizing for the station and its datapath widths, and a
// helper that locates a broadcast channel's slice inside a packed CDB bus.
package rs_station_age_pkg;

  localparam int RS_DEPTH_DEF = 16;
  localparam int N_CDB_DEF    = 2;
  localparam int DATA_W_DEF   = 32;
  localparam int ROB_W_DEF    = 4;
  localparam int OP_W_DEF     = 6;
  localparam int IMM_W_DEF    = 32;
  localparam int ADDR_W_DEF   = 32;

  // Lowest bit of channel `ch` in a bus packing `w`-bit fields per channel.
  function automatic int cdb_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker for the reservation station.
// Ports:
//   ready     - per-entry "busy and both operands available"
//   older     - age matrix, older[i][j] = 1 when entry i was allocated before j
//   sel_valid - at least one entry is ready
//   sel_idx   - index of the ready entry with no older ready entry
// Purely combinational.
module rs_age_select
  import rs_station_age_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF
) (
  input  logic [RS_DEPTH-1:0]               ready,
  input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older,
  output logic                              sel_valid,
  output logic [$clog2(RS_DEPTH)-1:0]       sel_idx
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0] cand;

  // An entry is a candidate when no other ready entry is older than it.
  // The age matrix is a strict total order over busy entries, so exactly one
  // candidate survives whenever any entry is ready; the encoder below only
  // converts that one-hot vector to an index.
  always_comb begin
    cand = ready;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (ready[j] && older[j][i]) cand[i] = 1'b0;
      end
    end
    sel_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_valid = |ready;

endmodule

// File: rtl/rs_station_age.sv
// Reservation station with age-ordered issue in front of one execution unit.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   ready           - global enable; low freezes every register
//   clear           - misprediction flush (empties station and issue register)
//   push_*          - dispatch handshake and instruction fields; a pending
//                     operand carries its ROB tag in the low ROB_W bits of v*
//   cdb_*           - N_CDB packed result broadcast channels
//   out_*           - registered issue port with valid/ready handshake
//   count, full     - registered occupancy of the station (issue reg excluded)
module rs_station_age
  import rs_station_age_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int N_CDB    = N_CDB_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ROB_W    = ROB_W_DEF,
  parameter int OP_W     = OP_W_DEF,
  parameter int IMM_W    = IMM_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ready,
  input  logic                      clear,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [OP_W-1:0]           push_op,
  input  logic [IMM_W-1:0]          push_imm,
  input  logic [ADDR_W-1:0]         push_pc,
  input  logic [ROB_W-1:0]          push_robpos,
  input  logic [DATA_W-1:0]         push_vj,
  input  logic [DATA_W-1:0]         push_vk,
  input  logic                      push_qj,
  input  logic                      push_qk,
  input  logic [N_CDB-1:0]          cdb_valid,
  input  logic [N_CDB*ROB_W-1:0]    cdb_robpos,
  input  logic [N_CDB*DATA_W-1:0]   cdb_val,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_W-1:0]           out_op,
  output logic [IMM_W-1:0]          out_imm,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [ROB_W-1:0]          out_robpos,
  output logic [DATA_W-1:0]         out_vj,
  output logic [DATA_W-1:0]         out_vk,
  output logic [$clog2(RS_DEPTH):0] count,
  output logic                      full
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Control state
  logic [RS_DEPTH-1:0]               busy_q, busy_d;
  logic [RS_DEPTH-1:0]               qj_q, qj_d;
  logic [RS_DEPTH-1:0]               qk_q, qk_d;
  logic [CNT_W-1:0]                  count_q, count_d;
  logic                              full_q, full_d;
  logic                              out_valid_q, out_valid_d;

  // Data state (no reset needed: only meaningful under busy/out_valid)
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;
  logic [OP_W-1:0]                   op_q  [RS_DEPTH];
  logic [OP_W-1:0]                   op_d  [RS_DEPTH];
  logic [IMM_W-1:0]                  imm_q [RS_DEPTH];
  logic [IMM_W-1:0]                  imm_d [RS_DEPTH];
  logic [ADDR_W-1:0]                 pc_q  [RS_DEPTH];
  logic [ADDR_W-1:0]                 pc_d  [RS_DEPTH];
  logic [ROB_W-1:0]                  rob_q [RS_DEPTH];
  logic [ROB_W-1:0]                  rob_d [RS_DEPTH];
  logic [DATA_W-1:0]                 vj_q  [RS_DEPTH];
  logic [DATA_W-1:0]                 vj_d  [RS_DEPTH];
  logic [DATA_W-1:0]                 vk_q  [RS_DEPTH];
  logic [DATA_W-1:0]                 vk_d  [RS_DEPTH];

  logic [OP_W-1:0]                   out_op_q, out_op_d;
  logic [IMM_W-1:0]                  out_imm_q, out_imm_d;
  logic [ADDR_W-1:0]                 out_pc_q, out_pc_d;
  logic [ROB_W-1:0]                  out_rob_q, out_rob_d;
  logic [DATA_W-1:0]                 out_vj_q, out_vj_d;
  logic [DATA_W-1:0]                 out_vk_q, out_vk_d;

  logic [RS_DEPTH-1:0]               rdy_vec;
  logic                              sel_valid;
  logic [IDX_W-1:0]                  sel_idx;
  logic [IDX_W-1:0]                  free_idx;
  logic                              push_fire;
  logic                              load_en;
  logic                              issue_load;

  // Returns {hit, value} for `tag`; the lowest-numbered matching channel wins.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [ROB_W-1:0]        tag,
    input logic [N_CDB-1:0]        vld,
    input logic [N_CDB*ROB_W-1:0]  tags,
    input logic [N_CDB*DATA_W-1:0] vals
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int c = N_CDB - 1; c >= 0; c--) begin
      if (vld[c] && (tags[cdb_lsb(c, ROB_W) +: ROB_W] == tag)) begin
        res = {1'b1, vals[cdb_lsb(c, DATA_W) +: DATA_W]};
      end
    end
    return res;
  endfunction

  assign push_ready = !full_q && ready && !reset && !clear;
  assign push_fire  = push_valid && push_ready;
  assign load_en    = ready && !reset && !clear && (!out_valid_q || out_ready);
  assign issue_load = load_en && sel_valid;

  // Selection looks only at registered state, so an entry pushed or woken
  // this cycle becomes selectable from the next cycle on.
  assign rdy_vec = busy_q & ~qj_q & ~qk_q;

  rs_age_select #(
    .RS_DEPTH (RS_DEPTH)
  ) u_age_select (
    .ready     (rdy_vec),
    .older     (older_q),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx)
  );

  // Lowest-index free slot; only used when the station is not full.
  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    logic [DATA_W:0] lk;
    busy_d      = busy_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    count_d     = count_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    older_d     = older_q;
    op_d        = op_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    rob_d       = rob_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    out_op_d    = out_op_q;
    out_imm_d   = out_imm_q;
    out_pc_d    = out_pc_q;
    out_rob_d   = out_rob_q;
    out_vj_d    = out_vj_q;
    out_vk_d    = out_vk_q;
    lk          = '0;

    if (reset || clear) begin
      busy_d      = '0;
      out_valid_d = 1'b0;
      count_d     = '0;
      full_d      = 1'b0;
    end else if (ready) begin
      // Wakeup of waiting operands from the broadcast channels
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy_q[i] && qj_q[i]) begin
          lk = cdb_lookup(vj_q[i][ROB_W-1:0], cdb_valid, cdb_robpos, cdb_val);
          if (lk[DATA_W]) begin
            vj_d[i] = lk[DATA_W-1:0];
            qj_d[i] = 1'b0;
          end
        end
        if (busy_q[i] && qk_q[i]) begin
          lk = cdb_lookup(vk_q[i][ROB_W-1:0], cdb_valid, cdb_robpos, cdb_val);
          if (lk[DATA_W]) begin
            vk_d[i] = lk[DATA_W-1:0];
            qk_d[i] = 1'b0;
          end
        end
      end

      // Issue register load; the chosen entry is already fully resolved
      if (load_en) begin
        out_valid_d = sel_valid;
        if (sel_valid) begin
          out_op_d        = op_q[sel_idx];
          out_imm_d       = imm_q[sel_idx];
          out_pc_d        = pc_q[sel_idx];
          out_rob_d       = rob_q[sel_idx];
          out_vj_d        = vj_q[sel_idx];
          out_vk_d        = vk_q[sel_idx];
          busy_d[sel_idx] = 1'b0;
        end
      end

      // Allocation; operands broadcast in this same cycle are captured here
      if (push_fire) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = push_op;
        imm_d[free_idx]  = push_imm;
        pc_d[free_idx]   = push_pc;
        rob_d[free_idx]  = push_robpos;
        vj_d[free_idx]   = push_vj;
        vk_d[free_idx]   = push_vk;
        qj_d[free_idx]   = push_qj;
        qk_d[free_idx]   = push_qk;
        if (push_qj) begin
          lk = cdb_lookup(push_vj[ROB_W-1:0], cdb_valid, cdb_robpos, cdb_val);
          if (lk[DATA_W]) begin
            vj_d[free_idx] = lk[DATA_W-1:0];
            qj_d[free_idx] = 1'b0;
          end
        end
        if (push_qk) begin
          lk = cdb_lookup(push_vk[ROB_W-1:0], cdb_valid, cdb_robpos, cdb_val);
          if (lk[DATA_W]) begin
            vk_d[free_idx] = lk[DATA_W-1:0];
            qk_d[free_idx] = 1'b0;
          end
        end
        // New entry is younger than every current occupant
        older_d[free_idx] = '0;
        for (int j = 0; j < RS_DEPTH; j++) begin
          older_d[j][free_idx] = busy_q[j];
        end
      end

      count_d = count_q + CNT_W'(push_fire) - CNT_W'(issue_load);
      full_d  = (count_d == CNT_W'(RS_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      qj_q        <= '0;
      qk_q        <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      count_q     <= count_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
    end
    older_q   <= older_d;
    op_q      <= op_d;
    imm_q     <= imm_d;
    pc_q      <= pc_d;
    rob_q     <= rob_d;
    vj_q      <= vj_d;
    vk_q      <= vk_d;
    out_op_q  <= out_op_d;
    out_imm_q <= out_imm_d;
    out_pc_q  <= out_pc_d;
    out_rob_q <= out_rob_d;
    out_vj_q  <= out_vj_d;
    out_vk_q  <= out_vk_d;
  end

  assign out_valid  = out_valid_q;
  assign out_op     = out_op_q;
  assign out_imm    = out_imm_q;
  assign out_pc     = out_pc_q;
  assign out_robpos = out_rob_q;
  assign out_vj     = out_vj_q;
  assign out_vk     = out_vk_q;
  assign count      = count_q;
  assign full       = full_q;

endmodule
